// File: rtl/alu_serial.sv
// Digit-serial ALU: DIGIT bits per cycle through a registered carry chain,
// valid/ready handshakes on both the operand and the result side.
module alu_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (WIDTH > DIGIT) ? (WIDTH - DIGIT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     res_q, res_d;
    logic [WIDTH-1:0]  f_q, f_d;
    logic              cout_q, cout_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;

    logic [DIGIT-1:0]  digit_s;
    logic              carry_out_s;
    logic              c_msb_in_s;
    logic              c_s;
    logic              ea_s;
    logic              eb_s;
    logic [WIDTH-1:0]  res_next_s;
    logic [RW-1:0]     res_shift_s;

    // One digit slice: effective operands, per-bit result and ripple carry.
    // c_msb_in_s ends up as the carry into the top bit of this digit.
    always_comb begin
        c_s        = carry_q;
        digit_s    = '0;
        c_msb_in_s = 1'b0;
        ea_s       = 1'b0;
        eb_s       = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            ea_s = a_q[i];
            eb_s = b_q[i];
            case (op_q)
                3'b100:  eb_s = 1'b0;
                3'b110:  eb_s = ~b_q[i];
                3'b111:  ea_s = ~a_q[i];
                default: eb_s = b_q[i];
            endcase
            c_msb_in_s = c_s;
            if (op_q[2]) begin
                digit_s[i] = ea_s ^ eb_s ^ c_s;
                c_s        = (ea_s & eb_s) | (c_s & (ea_s ^ eb_s));
            end else begin
                case (op_q[1:0])
                    2'b00:   digit_s[i] = ea_s & eb_s;
                    2'b01:   digit_s[i] = ea_s | eb_s;
                    2'b10:   digit_s[i] = ea_s ^ eb_s;
                    2'b11:   digit_s[i] = ~(ea_s ^ eb_s);
                    default: digit_s[i] = 1'b0;
                endcase
                c_s = 1'b0;
            end
        end
        carry_out_s = c_s;
    end

    // New digits enter at the top; after N steps the full result is aligned.
    if (DIGIT == WIDTH) begin : g_full
        assign res_next_s = digit_s;
    end else begin : g_part
        assign res_next_s = {digit_s, res_q};
    end
    assign res_shift_s = res_next_s[WIDTH-1 -: RW];

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        f_d     = f_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    carry_d = op[2] ? cin : 1'b0;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_shift_s;
                carry_d = carry_out_s;
                cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    f_d     = res_next_s;
                    cout_d  = carry_out_s;
                    zero_d  = (res_next_s == '0);
                    ovf_d   = op_q[2] & (c_msb_in_s ^ carry_out_s);
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 3'b000;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            f_q     <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            f_q     <= f_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign f         = f_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_serial.sv
// Directed bench for alu_serial at WIDTH=32, DIGIT=4 (8 RUN cycles).
module tb_alu_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] f;
    logic        cout;
    logic        zero;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    alu_serial #(.WIDTH(32), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .f(f), .cout(cout), .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Accept one operation, scramble the inputs, wait (bounded) for out_valid.
    task automatic do_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic ci, output int lat);
        in_valid = 1'b1; op = o; a = av; b = bv; cin = ci;
        @(posedge clk); #1;
        in_valid = 1'b0; op = ~o; a = 32'hDEADBEEF; b = 32'h12345678; cin = ~ci;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL op_timeout: out_valid=%b required 1", out_valid);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (f !== 32'h0) begin errors++; $display("FAIL rst_f: got %h want 0", f); end
        checks++; if ({cout, zero, ovf} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {cout, zero, ovf}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int lat;
        do_op(3'b101, 32'hFFFFFFFF, 32'h00000001, 1'b0, lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL add_latency: got %0d want 8", lat); end
        checks++; if (f !== 32'h0) begin errors++; $display("FAIL add_f: got %h want 00000000", f); end
        checks++; if ({cout, zero, ovf} !== 3'b110) begin errors++; $display("FAIL add_flags: got %b want 110", {cout, zero, ovf}); end
        consume();
        do_op(3'b101, 32'h7FFFFFFF, 32'h00000001, 1'b0, lat);
        checks++; if (f !== 32'h80000000) begin errors++; $display("FAIL ovf_f: got %h want 80000000", f); end
        checks++; if ({cout, zero, ovf} !== 3'b001) begin errors++; $display("FAIL ovf_flags: got %b want 001", {cout, zero, ovf}); end
        consume();
    endtask

    task automatic test_sub_inc();
        int lat;
        do_op(3'b110, 32'd5, 32'd7, 1'b1, lat);
        checks++; if (f !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_f: got %h want fffffffe", f); end
        checks++; if ({cout, zero, ovf} !== 3'b000) begin errors++; $display("FAIL sub_flags: got %b want 000", {cout, zero, ovf}); end
        consume();
        do_op(3'b111, 32'd5, 32'd7, 1'b1, lat);
        checks++; if (f !== 32'h2) begin errors++; $display("FAIL rsub_f: got %h want 00000002", f); end
        checks++; if ({cout, zero, ovf} !== 3'b100) begin errors++; $display("FAIL rsub_flags: got %b want 100", {cout, zero, ovf}); end
        consume();
        do_op(3'b100, 32'hFFFFFFFF, 32'h0, 1'b1, lat);
        checks++; if (f !== 32'h0) begin errors++; $display("FAIL inc_f: got %h want 00000000", f); end
        checks++; if ({cout, zero, ovf} !== 3'b110) begin errors++; $display("FAIL inc_flags: got %b want 110", {cout, zero, ovf}); end
        consume();
    endtask

    task automatic test_logic();
        int lat;
        do_op(3'b011, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, lat);
        checks++; if (f !== 32'h00FF00FF) begin errors++; $display("FAIL xnor_f: got %h want 00ff00ff", f); end
        checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL xnor_flags: got %b want 00", {cout, ovf}); end
        consume();
        do_op(3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b1, lat);
        checks++; if (f !== 32'h00F000F0) begin errors++; $display("FAIL and_f: got %h want 00f000f0", f); end
        checks++; if ({cout, zero, ovf} !== 3'b000) begin errors++; $display("FAIL and_flags: got %b want 000", {cout, zero, ovf}); end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        do_op(3'b101, 32'd3, 32'd4, 1'b0, lat);
        for (int k = 0; k < 5; k++) begin
            checks++; if (f !== 32'd7) begin errors++; $display("FAIL bp_f_stable: got %h want 00000007", f); end
            checks++; if ({in_ready, out_valid} !== 2'b01) begin errors++; $display("FAIL bp_handshake: got %b want 01", {in_ready, out_valid}); end
            checks++; if ({cout, zero, ovf} !== 3'b000) begin errors++; $display("FAIL bp_flags: got %b want 000", {cout, zero, ovf}); end
            if (k == 2) begin
                in_valid = 1'b1; op = 3'b101; a = 32'd100; b = 32'd100; cin = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        consume();
        checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL bp_release: got %b want 10", {in_ready, out_valid}); end
        do_op(3'b110, 32'h20, 32'h1, 1'b1, lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL bp_next_latency: got %0d want 8", lat); end
        checks++; if (f !== 32'h1F) begin errors++; $display("FAIL bp_next_f: got %h want 0000001f", f); end
        checks++; if ({cout, zero, ovf} !== 3'b100) begin errors++; $display("FAIL bp_next_flags: got %b want 100", {cout, zero, ovf}); end
        consume();
    endtask

    task automatic test_back_to_back();
        int gap;
        gap = 0;
        out_ready = 1'b1;
        in_valid = 1'b1; op = 3'b101; a = 32'd1; b = 32'd2; cin = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk); #1;
            if (in_ready && gap == 0) gap = k;
        end
        in_valid = 1'b0;
        checks++; if (gap !== 10) begin errors++; $display("FAIL b2b_period: got %0d want 10", gap); end
        for (int k = 0; k < 12 && !in_ready; k++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int seen;
        int lat;
        do_op(3'b110, 32'h20, 32'h1, 1'b1, lat);
        consume();
        in_valid = 1'b1; op = 3'b101; a = 32'd1; b = 32'd1; cin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL midrst_handshake: got %b want 10", {in_ready, out_valid}); end
        checks++; if (f !== 32'h0) begin errors++; $display("FAIL midrst_f: got %h want 00000000", f); end
        checks++; if ({cout, zero, ovf} !== 3'b000) begin errors++; $display("FAIL midrst_flags: got %b want 000", {cout, zero, ovf}); end
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_valid: got %0d pulses want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_inc();
        test_logic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
